// File: rtl/seqcheck_mc.sv
// seqcheck_mc - multi-channel sliding-window edge checker.
//
// Each of N asynchronous inputs is synchronised and edge-detected.
// The edge polarity is set by mode. Qualifying edges are counted over
// the last W cycles. A one-cycle hit pulse is raised when the count
// crosses the threshold k.
//
// Ports:
//   clk         single clock, all state on the rising edge
//   rst_n       synchronous active-low reset
//   in_sig      N asynchronous monitored inputs, bit i = channel i
//   mode        edge select: 00 rise, 01 fall, 10 both, 11 none
//   k           hit threshold; 0 disables hits
//   clr         synchronous clear of windows, counts, hit and sticky state
//   hit         per-channel 1-cycle pulse on threshold crossing
//   hit_sticky  per-channel latch of hit, held until clr or reset
//   any_hit     OR of hit, coincident with hit
//   count       per-channel window count, channel i at [i*SW +: SW]
module seqcheck_mc #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  parameter  int KW = 4,
  localparam int SW = $clog2(W + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_sig,
  input  logic [1:0]      mode,
  input  logic [KW-1:0]   k,
  input  logic            clr,
  output logic [N-1:0]    hit,
  output logic [N-1:0]    hit_sticky,
  output logic            any_hit,
  output logic [N*SW-1:0] count
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  // Common width for the count-vs-threshold compare, so neither side truncates.
  localparam int CW = (SW > KW) ? SW : KW;
  localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);

  logic [N-1:0]  s1_q, s2_q, prev_q;
  logic [N-1:0]  e;
  logic [N-1:0]  hit_q, hit_d;
  logic [N-1:0]  sticky_q;
  logic          any_q;
  logic [IW-1:0] idx_q, idx_d;

  // Threshold test. A zero threshold never fires.
  function automatic logic cond(input logic [SW-1:0] x, input logic [KW-1:0] th);
    return (th != '0) && (CW'(x) >= CW'(th));
  endfunction

  always_comb begin
    e = '0;
    case (mode)
      2'b00:   e = s2_q & ~prev_q;
      2'b01:   e = ~s2_q & prev_q;
      2'b10:   e = s2_q ^ prev_q;
      default: e = '0;
    endcase
  end

  assign idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

  // The synchronisers and prev keep running through clr, so the pipeline
  // stays coherent with the live inputs. Only the window state is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      idx_q    <= '0;
      hit_q    <= '0;
      sticky_q <= '0;
      any_q    <= 1'b0;
    end else begin
      s1_q   <= in_sig;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (clr) begin
        idx_q    <= '0;
        hit_q    <= '0;
        sticky_q <= '0;
        any_q    <= 1'b0;
      end else begin
        idx_q    <= idx_d;
        hit_q    <= hit_d;
        sticky_q <= sticky_q | hit_q;
        any_q    <= |hit_d;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic [W-1:0]  rb_q;
      logic [SW-1:0] cnt_q, cnt_d;
      logic          old_bit;

      // Slot about to be overwritten holds the edge that leaves the window.
      assign old_bit = rb_q[idx_q];
      // Subtract first: count >= old_bit always, so no intermediate wrap.
      assign cnt_d = cnt_q - SW'(old_bit) + SW'(e[gi]);
      // Fire only on the transition into the condition, so a change of k
      // alone cannot create a pulse.
      assign hit_d[gi] = cond(cnt_d, k) & ~cond(cnt_q, k);

      always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
          rb_q  <= '0;
          cnt_q <= '0;
        end else begin
          rb_q[idx_q] <= e[gi];
          cnt_q       <= cnt_d;
        end
      end

      assign count[gi*SW +: SW] = cnt_q;
    end
  endgenerate

  assign hit        = hit_q;
  assign hit_sticky = sticky_q;
  assign any_hit    = any_q;

endmodule
